// File: rtl/banked_mem_ctrl.sv
// Four-bank, word-interleaved main memory with a two-cycle read pipeline and per-bank busy counters.
// Define BANKED_MEM_CLEAR_EN to zero the whole array on every reset (simulation aid).
module banked_mem_ctrl #(
   parameter int BANK_WORDS  = 8192,
   parameter int BUSY_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_data_in,
   input  logic        mem_rd,
   input  logic        mem_wr,
   output logic [15:0] mem_DataOut,
   output logic        mem_rdv,
   output logic        mem_stall,
   output logic [3:0]  mem_busy,
   output logic        mem_err
);

   localparam int AW = $clog2(BANK_WORDS);

   logic [15:0]   mem_q [4][BANK_WORDS];
   logic [2:0]    cnt_q [4];
   logic [2:0]    cnt_d [4];
   logic [3:0]    busy_q;
   logic [3:0]    busy_d;
   logic          s1_v_q;
   logic [15:0]   s1_data_q;
   logic          rdv_q;
   logic [15:0]   dout_q;

   logic          req_s;
   logic          err_s;
   logic          stall_s;
   logic          accept_s;
   logic          rd_acc_s;
   logic          wr_acc_s;
   logic [1:0]    bank_s;
   logic [AW-1:0] word_s;
   logic [15:0]   rdata_s;

   assign bank_s  = mem_addr[2:1];
   assign word_s  = mem_addr[AW+2:3];
   assign rdata_s = mem_q[bank_s][word_s];

   // Request qualification and next-state of the bank occupancy counters.
   always_comb begin
      req_s    = mem_rd | mem_wr;
      err_s    = req_s & ((mem_rd & mem_wr) | mem_addr[0]);
      stall_s  = req_s & ~err_s & busy_q[bank_s];
      accept_s = req_s & ~err_s & ~stall_s;
      rd_acc_s = accept_s & mem_rd;
      wr_acc_s = accept_s & mem_wr;
      busy_d   = 4'b0000;
      for (int b = 0; b < 4; b++) begin
         if (accept_s && (bank_s == 2'(b))) begin
            cnt_d[b] = 3'(BUSY_CYCLES - 1);
         end else if (cnt_q[b] != 3'd0) begin
            cnt_d[b] = cnt_q[b] - 3'd1;
         end else begin
            cnt_d[b] = cnt_q[b];
         end
         busy_d[b] = (cnt_d[b] != 3'd0);
      end
   end

   // Busy counters and the two-stage read return pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 4; b++) begin
            cnt_q[b] <= 3'd0;
         end
         busy_q    <= 4'b0000;
         s1_v_q    <= 1'b0;
         s1_data_q <= 16'h0000;
         rdv_q     <= 1'b0;
         dout_q    <= 16'h0000;
      end else begin
         for (int b = 0; b < 4; b++) begin
            cnt_q[b] <= cnt_d[b];
         end
         busy_q    <= busy_d;
         s1_v_q    <= rd_acc_s;
         s1_data_q <= rd_acc_s ? rdata_s : 16'h0000;
         rdv_q     <= s1_v_q;
         dout_q    <= s1_v_q ? s1_data_q : 16'h0000;
      end
   end

`ifdef BANKED_MEM_CLEAR_EN
   // Storage array, wiped on every reset so benches see deterministic contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < BANK_WORDS; w++) begin
               mem_q[b][w] <= 16'h0000;
            end
         end
      end else if (wr_acc_s) begin
         mem_q[bank_s][word_s] <= mem_data_in;
      end else begin
         mem_q[bank_s][word_s] <= mem_q[bank_s][word_s];
      end
   end
`else
   // Storage array; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_q[bank_s][word_s] <= mem_data_in;
      end
   end
`endif

   assign mem_DataOut = dout_q;
   assign mem_rdv     = rdv_q;
   assign mem_busy    = busy_q;
   assign mem_stall   = stall_s;
   assign mem_err     = err_s;

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Bench for banked_mem_ctrl: directed vector table, async-reset sequence, and random traffic
// checked against a cycle-indexed reference model (last-accept time per bank, word map, read queue).
module tb_banked_mem_ctrl;

   localparam int BUSY = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mem_addr;
   logic [15:0] mem_data_in;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_DataOut;
   logic        mem_rdv;
   logic        mem_stall;
   logic [3:0]  mem_busy;
   logic        mem_err;

   banked_mem_ctrl #(.BANK_WORDS(8192), .BUSY_CYCLES(BUSY)) dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_DataOut(mem_DataOut), .mem_rdv(mem_rdv),
      .mem_stall(mem_stall), .mem_busy(mem_busy), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int due; logic [15:0] d; bit known; } rd_t;
   int          last_acc [4];
   logic [15:0] mm [int];
   rd_t         rq [$];

   task automatic model_reset();
      for (int b = 0; b < 4; b++) last_acc[b] = -100;
      rq.delete();
`ifdef BANKED_MEM_CLEAR_EN
      mm.delete();
`endif
   endtask

   function automatic bit bank_busy(int b);
      return (cyc - last_acc[b] >= 1) && (cyc - last_acc[b] <= BUSY - 1);
   endfunction

   task automatic model_step(input bit do_chk, output bit acc);
      bit req, e, s, ev, kn;
      int b;
      logic [3:0]  eb;
      logic [15:0] ed;
      req = mem_rd || mem_wr;
      e   = req && ((mem_rd && mem_wr) || mem_addr[0]);
      b   = int'(mem_addr[2:1]);
      s   = req && !e && bank_busy(b);
      acc = req && !e && !s;
      for (int k = 0; k < 4; k++) eb[k] = bank_busy(k);
      ev = (rq.size() > 0) && (rq[0].due == cyc);
      ed = ev ? rq[0].d : 16'h0000;
      kn = ev ? rq[0].known : 1'b1;
      if (do_chk) begin
         chk("err", {15'd0, mem_err}, {15'd0, e});
         chk("stall", {15'd0, mem_stall}, {15'd0, s});
         chk("busy", {12'd0, mem_busy}, {12'd0, eb});
         chk("rdv", {15'd0, mem_rdv}, {15'd0, ev});
         if (kn) chk("dout", mem_DataOut, ed);
      end
      if (ev) void'(rq.pop_front());
      if (acc) begin
         last_acc[b] = cyc;
         if (mem_wr) mm[int'(mem_addr[15:1])] = mem_data_in;
         else if (mm.exists(int'(mem_addr[15:1])))
            rq.push_back('{cyc + 2, mm[int'(mem_addr[15:1])], 1'b1});
         else
            rq.push_back('{cyc + 2, 16'h0000, 1'b0});
      end
   endtask

   task automatic drive(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
      mem_rd = rd; mem_wr = wr; mem_addr = a; mem_data_in = d;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit rd; bit wr; logic [15:0] a; logic [15:0] d;
      bit err; bit stall; logic [3:0] busy; bit rdv; logic [15:0] dout;
   } vec_t;
   vec_t tbl [$];

   function automatic void v(bit rd, bit wr, logic [15:0] a, logic [15:0] d,
                             bit e, bit s, logic [3:0] bz, bit rv, logic [15:0] q);
      tbl.push_back('{rd, wr, a, d, e, s, bz, rv, q});
   endfunction

   function automatic void idle(logic [3:0] bz, bit rv, logic [15:0] q);
      v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, bz, rv, q);
   endfunction

   logic [15:0] pool [8];
   bit          acc;

   initial begin
      // write, then read back after the bank frees
      v(1'b0, 1'b1, 16'h0102, 16'hBEEF, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0000);
      idle(4'b0010, 1'b0, 16'h0); idle(4'b0010, 1'b0, 16'h0); idle(4'b0010, 1'b0, 16'h0);
      v(1'b1, 1'b0, 16'h0102, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0000);
      idle(4'b0010, 1'b0, 16'h0); idle(4'b0010, 1'b1, 16'hBEEF);
      idle(4'b0010, 1'b0, 16'h0); idle(4'b0000, 1'b0, 16'h0);
      // line write-back then line fill, rotating banks every cycle
      v(1'b0, 1'b1, 16'h0040, 16'h1111, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0000);
      v(1'b0, 1'b1, 16'h0042, 16'h2222, 1'b0, 1'b0, 4'b0001, 1'b0, 16'h0000);
      v(1'b0, 1'b1, 16'h0044, 16'h3333, 1'b0, 1'b0, 4'b0011, 1'b0, 16'h0000);
      v(1'b0, 1'b1, 16'h0046, 16'h4444, 1'b0, 1'b0, 4'b0111, 1'b0, 16'h0000);
      v(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 4'b1110, 1'b0, 16'h0000);
      v(1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0, 1'b0, 4'b1101, 1'b0, 16'h0000);
      v(1'b1, 1'b0, 16'h0044, 16'h0000, 1'b0, 1'b0, 4'b1011, 1'b1, 16'h1111);
      v(1'b1, 1'b0, 16'h0046, 16'h0000, 1'b0, 1'b0, 4'b0111, 1'b1, 16'h2222);
      idle(4'b1110, 1'b1, 16'h3333); idle(4'b1100, 1'b1, 16'h4444);
      idle(4'b1000, 1'b0, 16'h0); idle(4'b0000, 1'b0, 16'h0);
      // same-bank conflict: held request stalls until the bank frees
      v(1'b0, 1'b1, 16'h0048, 16'h5555, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0000);
      idle(4'b0001, 1'b0, 16'h0); idle(4'b0001, 1'b0, 16'h0); idle(4'b0001, 1'b0, 16'h0);
      v(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0000);
      v(1'b1, 1'b0, 16'h0048, 16'h0000, 1'b0, 1'b1, 4'b0001, 1'b0, 16'h0000);
      v(1'b1, 1'b0, 16'h0048, 16'h0000, 1'b0, 1'b1, 4'b0001, 1'b1, 16'h1111);
      v(1'b1, 1'b0, 16'h0048, 16'h0000, 1'b0, 1'b1, 4'b0001, 1'b0, 16'h0000);
      v(1'b1, 1'b0, 16'h0048, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0000);
      idle(4'b0001, 1'b0, 16'h0); idle(4'b0001, 1'b1, 16'h5555); idle(4'b0001, 1'b0, 16'h0);
      // illegal requests have no side effects
      v(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000);
      v(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h0000);
      idle(4'b0000, 1'b0, 16'h0); idle(4'b0000, 1'b0, 16'h0);

      rst = 1'b1;
      mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = 16'h0000; mem_data_in = 16'h0000;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      chk("rst_dout", mem_DataOut, 16'h0000);
      chk("rst_rdv", {15'd0, mem_rdv}, 16'h0000);
      chk("rst_busy", {12'd0, mem_busy}, 16'h0000);
      chk("rst_stall", {15'd0, mem_stall}, 16'h0000);
      chk("rst_err", {15'd0, mem_err}, 16'h0000);
      rst = 1'b0;
      tick();

      foreach (tbl[i]) begin
         drive(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
         chk("t_err", {15'd0, mem_err}, {15'd0, tbl[i].err});
         chk("t_stall", {15'd0, mem_stall}, {15'd0, tbl[i].stall});
         chk("t_busy", {12'd0, mem_busy}, {12'd0, tbl[i].busy});
         chk("t_rdv", {15'd0, mem_rdv}, {15'd0, tbl[i].rdv});
         chk("t_dout", mem_DataOut, tbl[i].dout);
         model_step(1'b0, acc);
         tick();
      end

      // read in flight, then reset asserted asynchronously in the middle of the next cycle
      drive(1'b1, 1'b0, 16'h0040, 16'h0000);
      chk("ar_stall", {15'd0, mem_stall}, 16'h0000);
      model_step(1'b0, acc);
      tick();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000);
      chk("ar_busy_pre", {12'd0, mem_busy}, 16'h0001);
      rst = 1'b1;
      #1;
      chk("ar_busy", {12'd0, mem_busy}, 16'h0000);
      chk("ar_rdv", {15'd0, mem_rdv}, 16'h0000);
      chk("ar_dout", mem_DataOut, 16'h0000);
      @(posedge clk);
      #1;
      chk("ar_rdv_n2", {15'd0, mem_rdv}, 16'h0000);
      chk("ar_dout_n2", mem_DataOut, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 16'h0000, 16'h0000);
         model_step(1'b1, acc);
         tick();
      end

      // random traffic against the model; first seed a small pool of words
      for (int k = 0; k < 8; k++) pool[k] = 16'h0200 + 16'(k * 2);
      for (int k = 0; k < 8; k++) begin
         int tries = 0;
         acc = 1'b0;
         while (!acc && tries < 10) begin
            drive(1'b0, 1'b1, pool[k], 16'($urandom));
            model_step(1'b1, acc);
            tick();
            tries++;
         end
         if (!acc) begin
            n_cmp++; n_bad++;
            $display("FAIL seed_write k=%0d not accepted within 10 cycles", k);
         end
      end
      for (int i = 0; i < 600; i++) begin
         int r;
         logic [15:0] a;
         r = int'($urandom_range(0, 9));
         a = pool[$urandom_range(0, 7)];
         if (r <= 3)      drive(1'b1, 1'b0, a, 16'h0000);
         else if (r <= 6) drive(1'b0, 1'b1, a, 16'($urandom));
         else if (r == 7) drive(1'b0, 1'b0, a, 16'h0000);
         else if (r == 8) drive(1'b1, 1'b1, a, 16'($urandom));
         else             drive(1'b1, 1'b0, a | 16'h0001, 16'h0000);
         model_step(1'b1, acc);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 16'h0000, 16'h0000);
         model_step(1'b1, acc);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
